// File: rtl/wave_reader.sv
// Phase-accumulator oscillator: quarter-wave ROM lookup with quadrant folding, four waveforms,
// three-stage pipeline accepting one request per cycle and strobing each finished sample.
module wave_reader #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned FRAC_W   = 10,
    parameter int unsigned STEP_W   = 20,
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [STEP_W-1:0]   step_size,
    input  logic [1:0]          wave_sel,
    input  logic                phase_reset,
    input  logic                generate_next,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-2:0] rom_data,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_ready
);

    localparam int unsigned ACC_W = 2 + ADDR_W + FRAC_W;
    localparam int unsigned MAG_W = SAMPLE_W - 1;

    localparam logic [MAG_W-1:0]  MAG_MAX  = {MAG_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    localparam logic [1:0] SEL_SINE   = 2'b00;
    localparam logic [1:0] SEL_SQUARE = 2'b01;
    localparam logic [1:0] SEL_SAW    = 2'b10;

    logic [ACC_W-1:0]    phase;
    logic [ACC_W-1:0]    p_c;
    logic [ACC_W-1:0]    step_ext_c;

    // stage 1: fields of the accepted phase
    logic                s1_valid;
    logic [1:0]          s1_q;
    logic [ADDR_W-1:0]   s1_a;
    logic [MAG_W-1:0]    s1_f;
    logic [SAMPLE_W-1:0] s1_saw;
    logic [1:0]          s1_sel;

    // stage 2: waiting on ROM data
    logic                s2_valid;
    logic [1:0]          s2_q;
    logic [MAG_W-1:0]    s2_f;
    logic [SAMPLE_W-1:0] s2_saw;
    logic [1:0]          s2_sel;

    logic [MAG_W-1:0]    mag_c;
    logic [SAMPLE_W-1:0] mag_ext_c;
    logic [SAMPLE_W-1:0] wave_c;

    assign step_ext_c = ACC_W'(step_size);
    assign p_c        = phase_reset ? '0 : phase;

    // Magnitude selection and sign from the upper quadrant bit; sawtooth bypasses the fold.
    always_comb begin
        mag_c = rom_data;
        case (s2_sel)
            SEL_SINE:   mag_c = rom_data;
            SEL_SQUARE: mag_c = MAG_MAX;
            SEL_SAW:    mag_c = rom_data;
            default:    mag_c = s2_q[0] ? (MAG_MAX - s2_f) : s2_f;
        endcase
        mag_ext_c = {1'b0, mag_c};
        wave_c    = s2_q[1] ? -mag_ext_c : mag_ext_c;
        if (s2_sel == SEL_SAW) begin
            wave_c = s2_saw;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase        <= '0;
            s1_valid     <= 1'b0;
            s1_q         <= '0;
            s1_a         <= '0;
            s1_f         <= '0;
            s1_saw       <= '0;
            s1_sel       <= '0;
            s2_valid     <= 1'b0;
            s2_q         <= '0;
            s2_f         <= '0;
            s2_saw       <= '0;
            s2_sel       <= '0;
            rom_addr     <= '0;
            sample       <= '0;
            sample_ready <= 1'b0;
        end else begin
            phase    <= generate_next ? (p_c + step_ext_c) : p_c;
            s1_valid <= generate_next;
            if (generate_next) begin
                s1_q   <= p_c[ACC_W-1 -: 2];
                s1_a   <= p_c[ACC_W-3 -: ADDR_W];
                s1_f   <= p_c[ACC_W-3 -: MAG_W];
                s1_saw <= {~p_c[ACC_W-1], p_c[ACC_W-2 -: MAG_W]};
                s1_sel <= wave_sel;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                // odd quadrants read the quarter wave backwards
                rom_addr <= s1_q[0] ? (ADDR_MAX - s1_a) : s1_a;
                s2_q     <= s1_q;
                s2_f     <= s1_f;
                s2_saw   <= s1_saw;
                s2_sel   <= s1_sel;
            end

            sample_ready <= s2_valid;
            if (s2_valid) begin
                sample <= wave_c;
            end
        end
    end

endmodule
